// File: rtl/tap_stream_player_if.sv
// ioctl download bus between hps_io (master) and tap_stream_player (slave).
// Byte strobes are accepted every cycle; ioctl_wait asks the master to hold off.
interface tap_stream_player_if;
  logic       ioctl_download;
  logic [7:0] ioctl_index;
  logic       ioctl_wr;
  logic [7:0] ioctl_data;
  logic       ioctl_wait;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_data,
    input  ioctl_wait
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_data,
    output ioctl_wait
  );
endinterface

// File: rtl/tap_stream_player.sv
// TAP image -> byte FIFO -> pulse-width-coded EAR, muxed with the ADC tape-in; first ear rise 2 cycles
// after start, ioctl_wait while FIFO full, run=0 freezes playback. `TAP_PLAYER_LEADER_EN adds a leader tone.

// Generic byte FIFO, 1-cycle write-to-read, flush that can coexist with a push; caller must not push when full.
module tap_fifo #(
  parameter int AW = 2,
  parameter int DW = 8
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          flush,
  input  logic          push_vld,
  input  logic [DW-1:0] push_dat,
  input  logic          pop_vld,
  output logic [DW-1:0] pop_dat,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_addr;

  // A push on the flush cycle lands at the start of the emptied buffer.
  assign wr_addr = flush ? '0 : wr_ptr;

  always_ff @(posedge clk_sys) begin
    if (push_vld) mem[wr_addr] <= push_dat;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= push_vld ? AW'(1) : '0;
      rd_ptr <= '0;
      level  <= {{AW{1'b0}}, push_vld};
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + 1'b1;
      if (pop_vld)  rd_ptr <= rd_ptr + 1'b1;
      if (push_vld && !pop_vld)      level <= level + 1'b1;
      else if (!push_vld && pop_vld) level <= level - 1'b1;
    end
  end

  assign pop_dat = mem[rd_ptr];
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
endmodule

module tap_stream_player #(
  parameter int FIFO_AW       = 10,
  parameter int TAP_INDEX     = 1,
  parameter int TICK_DIV      = 24,
  parameter int HALF0_US      = 250,
  parameter int HALF1_US      = 500,
  parameter int LEADER_HALVES = 4096
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  tap_stream_player_if.slave   ioctl,
  input  logic                 motor,
  input  logic                 play_en,
  input  logic                 ear_adc,
  input  logic                 ear_adc_act,
  output logic                 ear,
  output logic                 busy,
  output logic                 overflow,
  output logic [FIFO_AW:0]     level
);
  localparam int HMAX = (HALF0_US > HALF1_US) ? HALF0_US : HALF1_US;
  localparam int HW   = $clog2(HMAX + 1);
  localparam int PW   = $clog2(TICK_DIV);
  localparam logic [HW-1:0] H0_LAST  = HW'(HALF0_US - 1);
  localparam logic [HW-1:0] H1_LAST  = HW'(HALF1_US - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  if (TICK_DIV < 2 || HALF0_US < 1 || HALF1_US < 1 || LEADER_HALVES < 1) begin : g_cfg_check
    $error("tap_stream_player: timing parameters out of range");
  end

`ifdef TAP_PLAYER_LEADER_EN
  localparam int LW = $clog2(LEADER_HALVES + 1);
  localparam logic [LW-1:0] LH_LAST = LW'(LEADER_HALVES - 1);
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_HIGH, ST_LOW, ST_LEADER} state_t;
  logic [LW-1:0] lcnt_q, lcnt_n;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_HIGH, ST_LOW} state_t;
`endif

  state_t        state_q, state_n;
  logic [PW-1:0] presc_q, presc_n;
  logic [HW-1:0] half_q, half_n;
  logic [HW-1:0] half_last;
  logic [7:0]    shreg_q, shreg_n;
  logic [2:0]    bitcnt_q, bitcnt_n;
  logic          sel, sel_q, flush, run;
  logic          full, empty, push_vld, pop_vld;
  logic [7:0]    pop_dat;
  logic          ear_tap;

  assign sel   = ioctl.ioctl_download && (ioctl.ioctl_index == 8'(TAP_INDEX));
  assign flush = sel && !sel_q;
  assign run   = motor && play_en;

  // The flush empties the FIFO this cycle, so a coinciding byte is still accepted.
  assign push_vld         = sel && ioctl.ioctl_wr && (!full || flush);
  assign ioctl.ioctl_wait = full;

  tap_fifo #(.AW(FIFO_AW), .DW(8)) u_fifo (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .flush    (flush),
    .push_vld (push_vld),
    .push_dat (ioctl.ioctl_data),
    .pop_vld  (pop_vld),
    .pop_dat  (pop_dat),
    .level    (level),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sel_q    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      sel_q <= sel;
      if (flush)                                 overflow <= 1'b0;
      else if (sel && ioctl.ioctl_wr && full)    overflow <= 1'b1;
    end
  end

  always_comb begin
    half_last = shreg_q[7] ? H1_LAST : H0_LAST;
`ifdef TAP_PLAYER_LEADER_EN
    if (state_q == ST_LEADER) half_last = H1_LAST;
`endif
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      presc_q  <= '0;
      half_q   <= '0;
      shreg_q  <= '0;
      bitcnt_q <= '0;
`ifdef TAP_PLAYER_LEADER_EN
      lcnt_q   <= '0;
`endif
    end else begin
      state_q  <= state_n;
      presc_q  <= presc_n;
      half_q   <= half_n;
      shreg_q  <= shreg_n;
      bitcnt_q <= bitcnt_n;
`ifdef TAP_PLAYER_LEADER_EN
      lcnt_q   <= lcnt_n;
`endif
    end
  end

  always_comb begin
    state_n  = state_q;
    presc_n  = presc_q;
    half_n   = half_q;
    shreg_n  = shreg_q;
    bitcnt_n = bitcnt_q;
    pop_vld  = 1'b0;
`ifdef TAP_PLAYER_LEADER_EN
    lcnt_n   = lcnt_q;
`endif
    if (flush) begin
      state_n = ST_IDLE;
      presc_n = '0;
      half_n  = '0;
    end else if (run) begin
      case (state_q)
        ST_IDLE: begin
          if (!empty) begin
`ifdef TAP_PLAYER_LEADER_EN
            state_n = ST_LEADER;
            lcnt_n  = '0;
`else
            state_n = ST_LOAD;
`endif
          end
        end
        ST_LOAD: begin
          if (empty) begin
            state_n = ST_IDLE;
          end else begin
            pop_vld  = 1'b1;
            shreg_n  = pop_dat;
            bitcnt_n = 3'd7;
            state_n  = ST_HIGH;
          end
        end
        default: begin
          // Timed half-period: prescaler restarts with every half so each lasts exactly H*TICK_DIV.
          if (presc_q != PRE_LAST) begin
            presc_n = presc_q + 1'b1;
          end else begin
            presc_n = '0;
            if (half_q != half_last) begin
              half_n = half_q + 1'b1;
            end else begin
              half_n = '0;
              if (state_q == ST_HIGH) begin
                state_n = ST_LOW;
              end else if (state_q == ST_LOW) begin
                if (bitcnt_q != 3'd0) begin
                  shreg_n  = {shreg_q[6:0], 1'b0};
                  bitcnt_n = bitcnt_q - 3'd1;
                  state_n  = ST_HIGH;
                end else if (!empty) begin
                  state_n = ST_LOAD;
                end else begin
                  state_n = ST_IDLE;
                end
              end
`ifdef TAP_PLAYER_LEADER_EN
              else begin
                if (lcnt_q == LH_LAST) state_n = ST_LOAD;
                else                   lcnt_n  = lcnt_q + 1'b1;
              end
`endif
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    ear_tap = (state_q == ST_HIGH);
`ifdef TAP_PLAYER_LEADER_EN
    // Leader halves alternate starting high: even count = high.
    if (state_q == ST_LEADER) ear_tap = ~lcnt_q[0];
`endif
  end

  assign busy = (state_q != ST_IDLE);
  assign ear  = busy ? ear_tap : (ear_adc_act & ear_adc);
endmodule

// File: tb/tb_tap_stream_player.sv
// Bench for tap_stream_player: table-driven byte playback scored against an ear-segment queue,
// plus hand sequences for pause, back-pressure, flush, index select and asynchronous reset.
module tb_tap_stream_player;
  localparam int AW = 3, TD = 2, H0 = 3, H1 = 5, LH = 4, TAPIDX = 1;
`ifdef TAP_PLAYER_LEADER_EN
  localparam int LEAD_CYC = LH * H1 * TD;
`else
  localparam int LEAD_CYC = 0;
`endif
  localparam int T1_LVL = (LEAD_CYC > 0) ? 6 : 5;

  logic clk_sys = 1'b0;
  logic reset = 1'b1;
  logic motor = 1'b0, play_en = 1'b0, ear_adc = 1'b0, ear_adc_act = 1'b0;
  logic ear, busy, overflow;
  logic [AW:0] level;

  tap_stream_player_if io ();

  tap_stream_player #(
    .FIFO_AW(AW), .TAP_INDEX(TAPIDX), .TICK_DIV(TD),
    .HALF0_US(H0), .HALF1_US(H1), .LEADER_HALVES(LH)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl(io), .motor(motor), .play_en(play_en),
    .ear_adc(ear_adc), .ear_adc_act(ear_adc_act), .ear(ear), .busy(busy),
    .overflow(overflow), .level(level)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0, n_err = 0;

  typedef struct { logic val; int len; } seg_t;
  typedef struct { logic act; logic adc; logic exp; } mux_t;
  typedef struct { logic [7:0] dat; logic adc_on; int exp_busy; } vec_t;

  seg_t sb_q[$];
  bit   mon_en = 1'b0;
  logic seg_val = 1'b0;
  int   seg_len = 0, busy_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic void add_seg(input logic v, input int len);
    if (sb_q.size() > 0 && sb_q[sb_q.size()-1].val == v) begin
      seg_t t = sb_q[sb_q.size()-1];
      t.len += len;
      sb_q[sb_q.size()-1] = t;
    end else begin
      seg_t t;
      t.val = v;
      t.len = len;
      sb_q.push_back(t);
    end
  endfunction

  function automatic void expect_start();
`ifdef TAP_PLAYER_LEADER_EN
    for (int i = 0; i < LH; i++) add_seg(((i % 2) == 0), H1 * TD);
`endif
  endfunction

  // One LOAD cycle (ear low) then 8 bits MSB first, each a high half and a low half.
  function automatic void expect_byte(input logic [7:0] b);
    add_seg(1'b0, 1);
    for (int i = 7; i >= 0; i--) begin
      int h;
      h = b[i] ? H1 : H0;
      add_seg(1'b1, h * TD);
      add_seg(1'b0, h * TD);
    end
  endfunction

  task automatic check_seg();
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL seg_extra: got ear=%0d for %0d cycles, want no segment", seg_val, seg_len);
    end else begin
      seg_t e;
      e = sb_q.pop_front();
      chk("seg_val", 32'(seg_val), 32'(e.val));
      chk("seg_len", 32'(seg_len), 32'(e.len));
    end
  endtask

  // Measures ear run lengths over busy cycles in which the player is running.
  always @(negedge clk_sys) begin
    if (mon_en) begin
      if (busy) begin
        if (motor && play_en) begin
          busy_cyc++;
          if (seg_len != 0 && ear !== seg_val) begin
            check_seg();
            seg_len = 0;
          end
          seg_val = ear;
          seg_len++;
        end
      end else if (seg_len != 0) begin
        check_seg();
        seg_len = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    io.ioctl_wr   = 1'b1;
    io.ioctl_data = b;
    tick(1);
    io.ioctl_wr   = 1'b0;
  endtask

  task automatic start_download(input logic [7:0] idx);
    io.ioctl_download = 1'b0;
    tick(1);
    io.ioctl_index    = idx;
    io.ioctl_download = 1'b1;
    tick(1);
  endtask

  task automatic wait_ear(input logic v, input int budget, input string name);
    int n = 0;
    while (ear !== v && n < budget) begin
      tick(1);
      n++;
    end
    chk(name, 32'(ear), 32'(v));
  endtask

  task automatic start_mon();
    seg_len  = 0;
    busy_cyc = 0;
    mon_en   = 1'b1;
  endtask

  task automatic run_until_idle(input int budget, input string name);
    int n = 0;
    bit seen;
    seen = busy;
    while (!(seen && !busy) && n < budget) begin
      tick(1);
      n++;
      if (busy) seen = 1'b1;
    end
    @(negedge clk_sys);
    #1;
    chk({name, "_seen_busy"}, 32'(seen), 32'd1);
    chk({name, "_idle"}, 32'(busy), 32'd0);
    mon_en = 1'b0;
    chk({name, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    mux_t mux_tab[4];
    vec_t tab[5];
    int   bad;

    mux_tab[0] = '{1'b1, 1'b1, 1'b1};
    mux_tab[1] = '{1'b0, 1'b1, 1'b0};
    mux_tab[2] = '{1'b1, 1'b0, 1'b0};
    mux_tab[3] = '{1'b0, 1'b0, 1'b0};
    tab[0] = '{8'hA5, 1'b0, 129};
    tab[1] = '{8'h00, 1'b0, 97};
    tab[2] = '{8'hFF, 1'b1, 161};
    tab[3] = '{8'h3C, 1'b0, 129};
    tab[4] = '{8'h81, 1'b1, 113};

    io.ioctl_download = 1'b0;
    io.ioctl_index    = 8'd0;
    io.ioctl_wr       = 1'b0;
    io.ioctl_data     = 8'd0;

    // Reset state
    #12;
    chk("rst_ear", 32'(ear), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_wait", 32'(io.ioctl_wait), 32'd0);
    #3 reset = 1'b0;
    tick(2);

    // Idle mux to the ADC path
    for (int i = 0; i < 4; i++) begin
      ear_adc_act = mux_tab[i].act;
      ear_adc     = mux_tab[i].adc;
      #1;
      chk("mux_idle", 32'(ear), 32'(mux_tab[i].exp));
    end
    ear_adc_act = 1'b0;
    ear_adc     = 1'b0;

    start_download(8'(TAPIDX));

    // Single-byte playback vectors
    for (int i = 0; i < 5; i++) begin
      ear_adc     = tab[i].adc_on;
      ear_adc_act = tab[i].adc_on;
      push_byte(tab[i].dat);
      chk("vec_level", 32'(level), 32'd1);
      expect_start();
      expect_byte(tab[i].dat);
      start_mon();
      motor   = 1'b1;
      play_en = 1'b1;
      run_until_idle(1000, "vec_run");
      chk("vec_busy_cyc", 32'(busy_cyc), 32'(tab[i].exp_busy + LEAD_CYC));
      chk("vec_ear_adc", 32'(ear), 32'(tab[i].adc_on));
      motor       = 1'b0;
      play_en     = 1'b0;
      ear_adc     = 1'b0;
      ear_adc_act = 1'b0;
    end

    // Back-to-back bytes: LOAD between bytes, one leader only
    push_byte(8'h5A);
    push_byte(8'hC3);
    chk("stream_level", 32'(level), 32'd2);
    expect_start();
    expect_byte(8'h5A);
    expect_byte(8'hC3);
    start_mon();
    motor   = 1'b1;
    play_en = 1'b1;
    run_until_idle(2000, "stream_run");
    chk("stream_busy_cyc", 32'(busy_cyc), 32'(258 + LEAD_CYC));
    motor   = 1'b0;
    play_en = 1'b0;

    // Pause in the middle of a low half
    push_byte(8'h00);
    expect_start();
    expect_byte(8'h00);
    start_mon();
    motor   = 1'b1;
    play_en = 1'b1;
    wait_ear(1'b1, 200, "t4_rise");
    wait_ear(1'b0, 200, "t4_fall");
    tick(2);
    play_en = 1'b0;
    bad = 0;
    repeat (100) begin
      tick(1);
      if (ear !== 1'b0 || busy !== 1'b1) bad++;
    end
    chk("t4_pause_hold", 32'(bad), 32'd0);
    play_en = 1'b1;
    run_until_idle(1000, "t4_run");
    chk("t4_busy_cyc", 32'(busy_cyc), 32'(97 + LEAD_CYC));
    motor   = 1'b0;
    play_en = 1'b0;

    // Back-pressure and overflow with the player stopped
    start_download(8'(TAPIDX));
    for (int i = 0; i < 10; i++) begin
      int exp_lvl;
      exp_lvl = (i + 1 > 8) ? 8 : i + 1;
      push_byte(8'(8'hF0 + i));
      chk("t3_level", 32'(level), 32'(exp_lvl));
      chk("t3_wait", 32'(io.ioctl_wait), 32'(exp_lvl == 8));
      chk("t3_overflow", 32'(overflow), 32'(i >= 8));
    end

    // Flush by a new download edge during playback
    motor   = 1'b1;
    play_en = 1'b1;
    wait_ear(1'b1, 200, "t5_rise");
    tick(3);
    chk("t5_busy_pre", 32'(busy), 32'd1);
    io.ioctl_download = 1'b0;
    tick(1);
    io.ioctl_download = 1'b1;
    tick(1);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_level", 32'(level), 32'd0);
    chk("t5_overflow", 32'(overflow), 32'd0);
    tick(5);
    chk("t5_stay_idle", 32'(busy), 32'd0);

    // Download to another index is ignored
    io.ioctl_index = 8'd2;
    tick(1);
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    chk("t5_idx_level", 32'(level), 32'd0);
    chk("t5_idx_busy", 32'(busy), 32'd0);
    motor   = 1'b0;
    play_en = 1'b0;

    // Asynchronous reset in the middle of a high half
    start_download(8'(TAPIDX));
    for (int i = 0; i < 6; i++) push_byte(8'hFF);
    motor   = 1'b1;
    play_en = 1'b1;
    wait_ear(1'b1, 200, "t1_rise");
    tick(3);
    chk("t1_level_pre", 32'(level), 32'(T1_LVL));
    chk("t1_ear_pre", 32'(ear), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t1_ear", 32'(ear), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_level", 32'(level), 32'd0);
    chk("t1_wait", 32'(io.ioctl_wait), 32'd0);
    chk("t1_overflow", 32'(overflow), 32'd0);
    #10 reset = 1'b0;
    motor   = 1'b0;
    play_en = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
